// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package ctrl_pkg;

    localparam int unsigned OP_W      = 7;
    localparam int unsigned F3_W      = 3;
    localparam int unsigned ALUCTRL_W = 3;
    localparam int unsigned SEL_W     = 2;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // opcodes of the supported subset
    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

    // funct3 values understood by the ALU decoder
    localparam logic [F3_W-1:0] F3_ADD = 3'b000;
    localparam logic [F3_W-1:0] F3_SLT = 3'b010;
    localparam logic [F3_W-1:0] F3_OR  = 3'b110;
    localparam logic [F3_W-1:0] F3_AND = 3'b111;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUCTRL_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = 3'b101;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] IMM_I = 2'b00;
    localparam logic [SEL_W-1:0] IMM_S = 2'b01;
    localparam logic [SEL_W-1:0] IMM_B = 2'b10;
    localparam logic [SEL_W-1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_controller_if.sv
// Instruction fields, status inputs and datapath controls between controller and datapath.
interface mc_controller_if;
    import ctrl_pkg::*;

    logic [OP_W-1:0]      op;
    logic [F3_W-1:0]      funct3;
    logic                 funct7b5;
    logic                 Zero;
    logic                 MemReady;

    logic                 PCWrite;
    logic                 AdrSrc;
    logic                 MemWrite;
    logic                 IRWrite;
    logic                 RegWrite;
    logic [SEL_W-1:0]     ResultSrc;
    logic [SEL_W-1:0]     ALUSrcA;
    logic [SEL_W-1:0]     ALUSrcB;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic [SEL_W-1:0]     ImmSrc;
    logic                 Illegal;

    modport master (
        input  op, funct3, funct7b5, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal
    );

    modport slave (
        output op, funct3, funct7b5, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal
    );

endinterface

// File: rtl/aludec.sv
// ALU decoder: maps ALUOp and instruction function bits to an ALU operation.
module aludec
    import ctrl_pkg::*;
(
    input  aluop_t               aluop,
    input  logic [F3_W-1:0]      funct3,
    input  logic                 funct7b5,
    input  logic                 op5,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic                 illegal_funct
);

    logic [ALUCTRL_W-1:0] funct_ctrl;

    // funct3 decode; the illegal flag is valid regardless of ALUOp so DECODE can use it
    always_comb begin
        funct_ctrl    = ALU_ADD;
        illegal_funct = 1'b0;
        case (funct3)
            F3_ADD:  funct_ctrl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
            F3_SLT:  funct_ctrl = ALU_SLT;
            F3_OR:   funct_ctrl = ALU_OR;
            F3_AND:  funct_ctrl = ALU_AND;
            default: illegal_funct = 1'b1;
        endcase
    end

    // final operation select by ALUOp
    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = funct_ctrl;
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I controller: Moore sequencer driving a shared-memory datapath.
module mc_controller
    import ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    mc_controller_if.master bus
);

    state_t state;
    state_t state_next;
    aluop_t aluop;
    logic   illegal_funct;

    aludec u_aludec (
        .aluop         (aluop),
        .funct3        (bus.funct3),
        .funct7b5      (bus.funct7b5),
        .op5           (bus.op[5]),
        .alu_control   (bus.ALUControl),
        .illegal_funct (illegal_funct)
    );

    // state register, forced to FETCH while reset is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // next state and per-state datapath controls
    always_comb begin
        state_next    = state;
        aluop         = ALUOP_ADD;
        bus.PCWrite   = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.Illegal   = 1'b0;
        bus.ResultSrc = RES_ALUOUT;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_RS2;

        case (state)
            S_FETCH: begin
                bus.ALUSrcA   = SRCA_PC;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURESULT;
                bus.IRWrite   = bus.MemReady;
                bus.PCWrite   = bus.MemReady;
                state_next    = bus.MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // branch target precomputed into ALUOut
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
                state_next  = S_FETCH;
                case (bus.op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R: begin
                        bus.Illegal = illegal_funct;
                        state_next  = illegal_funct ? S_FETCH : S_EXECR;
                    end
                    OP_I: begin
                        bus.Illegal = illegal_funct;
                        state_next  = illegal_funct ? S_FETCH : S_EXECI;
                    end
                    OP_BEQ: begin
                        bus.Illegal = (bus.funct3 != F3_ADD);
                        state_next  = (bus.funct3 != F3_ADD) ? S_FETCH : S_BEQ;
                    end
                    OP_JAL:  state_next = S_JAL;
                    default: bus.Illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_IMM;
                state_next  = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                bus.AdrSrc = 1'b1;
                state_next = bus.MemReady ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                bus.ResultSrc = RES_DATA;
                bus.RegWrite  = 1'b1;
                state_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                // strobe held through stalls; the write commits on the ready edge
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
                state_next   = bus.MemReady ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_RS2;
                aluop       = ALUOP_FUNCT;
                state_next  = S_ALUWB;
            end
            S_EXECI: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_IMM;
                aluop       = ALUOP_FUNCT;
                state_next  = S_ALUWB;
            end
            S_ALUWB: begin
                bus.RegWrite = 1'b1;
                state_next   = S_FETCH;
            end
            S_JAL: begin
                // return address OldPC+4 into ALUOut, PC takes the target already in ALUOut
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_FOUR;
                bus.PCWrite = 1'b1;
                state_next  = S_ALUWB;
            end
            S_BEQ: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_RS2;
                aluop       = ALUOP_SUB;
                bus.PCWrite = bus.Zero;
                state_next  = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase

        // no enable may reach an edge while reset is asserted
        if (!reset) begin
            bus.PCWrite  = 1'b0;
            bus.IRWrite  = 1'b0;
            bus.RegWrite = 1'b0;
            bus.MemWrite = 1'b0;
            bus.Illegal  = 1'b0;
        end
    end

    // immediate format depends only on the opcode
    always_comb begin
        bus.ImmSrc = IMM_I;
        case (bus.op)
            OP_SW:   bus.ImmSrc = IMM_S;
            OP_BEQ:  bus.ImmSrc = IMM_B;
            OP_JAL:  bus.ImmSrc = IMM_J;
            default: bus.ImmSrc = IMM_I;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: per-instruction vectors with a scoreboard of expected summaries.
module tb_mc_controller;
    import ctrl_pkg::*;

    localparam int MAXC = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mc_controller_if bus();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string      nm;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        int         stall_at;
        int         stall_n;
        int         cycles;
        int         regw;
        logic [1:0] wbres;
        int         memw;
        int         adr;
        int         pcw;
        int         ill;
        logic [2:0] alu2;
        logic [1:0] srca2;
        logic [1:0] srcb2;
        logic [1:0] imm;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(string nm, logic [6:0] op, logic [2:0] f3, logic f7, logic zero,
                                int sa, int sn, int cyc, int regw, logic [1:0] wbres, int memw,
                                int adr, int pcw, int ill, logic [2:0] alu2, logic [1:0] srca2,
                                logic [1:0] srcb2, logic [1:0] imm);
        return '{nm, op, f3, f7, zero, sa, sn, cyc, regw, wbres, memw, adr, pcw, ill,
                 alu2, srca2, srcb2, imm};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Run one instruction from its FETCH cycle up to the start of the next FETCH.
    task automatic run_instr(input vec_t v);
        int cyc, regw, memw, adr, pcw, ill, pos;
        logic [1:0] wbres, srca2, srcb2, imm;
        logic [2:0] alu2;
        bit seen, done;
        vec_t e;
        exp_q.push_back(v);
        bus.op = v.op;
        bus.funct3 = v.f3;
        bus.funct7b5 = v.f7;
        bus.Zero = v.zero;
        cyc = 0; regw = 0; memw = 0; adr = 0; pcw = 0; ill = 0; pos = 0;
        wbres = 2'b00; srca2 = 2'b00; srcb2 = 2'b00; imm = 2'b00; alu2 = 3'b000;
        seen = 1'b0; done = 1'b0;
        for (int k = 0; k < MAXC; k++) begin
            if (k > 0) @(negedge clk);
            bus.MemReady = (k >= v.stall_at && k < v.stall_at + v.stall_n) ? 1'b0 : 1'b1;
            #1;
            if (bus.IRWrite && seen) begin
                done = 1'b1;
                break;
            end
            if (seen) pos++;
            if (bus.IRWrite) seen = 1'b1;
            cyc++;
            if (bus.RegWrite) begin
                regw++;
                wbres = bus.ResultSrc;
            end
            if (bus.MemWrite) memw++;
            if (bus.AdrSrc) adr++;
            if (bus.PCWrite && !bus.IRWrite) pcw++;
            if (bus.Illegal) ill++;
            if (seen && pos == 1) imm = bus.ImmSrc;
            if (seen && pos == 2) begin
                alu2  = bus.ALUControl;
                srca2 = bus.ALUSrcA;
                srcb2 = bus.ALUSrcB;
            end
        end
        e = exp_q.pop_front();
        chk({e.nm, " completes"}, int'(done), 1);
        chk({e.nm, " cycles"}, cyc, e.cycles);
        chk({e.nm, " regwrite"}, regw, e.regw);
        chk({e.nm, " wb_resultsrc"}, int'(wbres), int'(e.wbres));
        chk({e.nm, " memwrite"}, memw, e.memw);
        chk({e.nm, " adrsrc"}, adr, e.adr);
        chk({e.nm, " pcwrite"}, pcw, e.pcw);
        chk({e.nm, " illegal"}, ill, e.ill);
        chk({e.nm, " alucontrol"}, int'(alu2), int'(e.alu2));
        chk({e.nm, " alusrca"}, int'(srca2), int'(e.srca2));
        chk({e.nm, " alusrcb"}, int'(srcb2), int'(e.srcb2));
        chk({e.nm, " immsrc"}, int'(imm), int'(e.imm));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // name op f3 f7 zero stall_at stall_n | cycles regw wbres memw adr pcw ill alu srca srcb imm
        vecs.push_back(mk("lw",      7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, 5, 1, 2'b01, 0, 1, 0, 0, 3'b000, 2'b10, 2'b01, 2'b00));
        vecs.push_back(mk("sw",      7'b0100011, 3'b010, 1'b0, 1'b0, 0, 0, 4, 0, 2'b00, 1, 1, 0, 0, 3'b000, 2'b10, 2'b01, 2'b01));
        vecs.push_back(mk("add",     7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 4, 1, 2'b00, 0, 0, 0, 0, 3'b000, 2'b10, 2'b00, 2'b00));
        vecs.push_back(mk("sub",     7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, 4, 1, 2'b00, 0, 0, 0, 0, 3'b001, 2'b10, 2'b00, 2'b00));
        vecs.push_back(mk("and",     7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0, 4, 1, 2'b00, 0, 0, 0, 0, 3'b010, 2'b10, 2'b00, 2'b00));
        vecs.push_back(mk("or",      7'b0110011, 3'b110, 1'b0, 1'b0, 0, 0, 4, 1, 2'b00, 0, 0, 0, 0, 3'b011, 2'b10, 2'b00, 2'b00));
        vecs.push_back(mk("slt",     7'b0110011, 3'b010, 1'b0, 1'b0, 0, 0, 4, 1, 2'b00, 0, 0, 0, 0, 3'b101, 2'b10, 2'b00, 2'b00));
        vecs.push_back(mk("addi_b30",7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, 4, 1, 2'b00, 0, 0, 0, 0, 3'b000, 2'b10, 2'b01, 2'b00));
        vecs.push_back(mk("andi",    7'b0010011, 3'b111, 1'b0, 1'b0, 0, 0, 4, 1, 2'b00, 0, 0, 0, 0, 3'b010, 2'b10, 2'b01, 2'b00));
        vecs.push_back(mk("ori",     7'b0010011, 3'b110, 1'b0, 1'b0, 0, 0, 4, 1, 2'b00, 0, 0, 0, 0, 3'b011, 2'b10, 2'b01, 2'b00));
        vecs.push_back(mk("slti",    7'b0010011, 3'b010, 1'b0, 1'b0, 0, 0, 4, 1, 2'b00, 0, 0, 0, 0, 3'b101, 2'b10, 2'b01, 2'b00));
        vecs.push_back(mk("beq_z1",  7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, 3, 0, 2'b00, 0, 0, 1, 0, 3'b001, 2'b10, 2'b00, 2'b10));
        vecs.push_back(mk("beq_z0",  7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, 3, 0, 2'b00, 0, 0, 0, 0, 3'b001, 2'b10, 2'b00, 2'b10));
        vecs.push_back(mk("jal",     7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, 4, 1, 2'b00, 0, 0, 1, 0, 3'b000, 2'b01, 2'b10, 2'b11));
        vecs.push_back(mk("ill_op",  7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, 2, 0, 2'b00, 0, 0, 0, 1, 3'b000, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk("ill_r001",7'b0110011, 3'b001, 1'b0, 1'b0, 0, 0, 2, 0, 2'b00, 0, 0, 0, 1, 3'b000, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk("ill_i011",7'b0010011, 3'b011, 1'b0, 1'b0, 0, 0, 2, 0, 2'b00, 0, 0, 0, 1, 3'b000, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk("ill_beq", 7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0, 2, 0, 2'b00, 0, 0, 0, 1, 3'b000, 2'b00, 2'b00, 2'b10));
        vecs.push_back(mk("sw_stall",7'b0100011, 3'b010, 1'b0, 1'b0, 3, 3, 7, 0, 2'b00, 4, 4, 0, 0, 3'b000, 2'b10, 2'b01, 2'b01));
        vecs.push_back(mk("lw_stall",7'b0000011, 3'b010, 1'b0, 1'b0, 3, 2, 7, 1, 2'b01, 0, 3, 0, 0, 3'b000, 2'b10, 2'b01, 2'b00));
        vecs.push_back(mk("add_fstall",7'b0110011,3'b000,1'b0, 1'b0, 0, 2, 6, 1, 2'b00, 0, 0, 0, 0, 3'b000, 2'b10, 2'b00, 2'b00));

        // reset asserted with an edge-triggered falling transition
        reset = 1'b1;
        bus.MemReady = 1'b1;
        bus.op = 7'b0000011;
        bus.funct3 = 3'b010;
        bus.funct7b5 = 1'b0;
        bus.Zero = 1'b0;
        #1 reset = 1'b0;
        #2;
        chk("rst pcwrite", int'(bus.PCWrite), 0);
        chk("rst irwrite", int'(bus.IRWrite), 0);
        chk("rst regwrite", int'(bus.RegWrite), 0);
        chk("rst memwrite", int'(bus.MemWrite), 0);
        chk("rst illegal", int'(bus.Illegal), 0);
        chk("rst adrsrc", int'(bus.AdrSrc), 0);
        chk("rst alusrca", int'(bus.ALUSrcA), 0);
        chk("rst alusrcb", int'(bus.ALUSrcB), 2);
        chk("rst resultsrc", int'(bus.ResultSrc), 2);
        chk("rst alucontrol", int'(bus.ALUControl), 0);
        @(negedge clk);
        #1 chk("rst held irwrite", int'(bus.IRWrite), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_instr(vecs[i]);
        end

        // reset dropped in the middle of a stalled store
        bus.op = 7'b0100011;
        bus.funct3 = 3'b010;
        bus.funct7b5 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bus.MemReady = 1'b0;
        #1;
        chk("memwrite before reset", int'(bus.MemWrite), 1);
        chk("adrsrc before reset", int'(bus.AdrSrc), 1);
        #1 reset = 1'b0;
        #1;
        chk("mid rst memwrite", int'(bus.MemWrite), 0);
        chk("mid rst adrsrc", int'(bus.AdrSrc), 0);
        chk("mid rst pcwrite", int'(bus.PCWrite), 0);
        chk("mid rst irwrite", int'(bus.IRWrite), 0);
        chk("mid rst regwrite", int'(bus.RegWrite), 0);
        chk("mid rst alusrcb", int'(bus.ALUSrcB), 2);
        bus.MemReady = 1'b1;
        #1;
        chk("mid rst irwrite ready", int'(bus.IRWrite), 0);
        chk("mid rst pcwrite ready", int'(bus.PCWrite), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("release irwrite", int'(bus.IRWrite), 1);
        chk("release pcwrite", int'(bus.PCWrite), 1);
        run_instr(mk("post_rst_add", 7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 4, 1, 2'b00, 0, 0, 0, 0,
                     3'b000, 2'b10, 2'b00, 2'b00));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the RV32I core: a Moore state machine plus ALU decoder that sequences a shared-memory multicycle datapath (single memory port for instruction and data, instruction register, old-PC, data and ALUOut registers). It decodes the instruction register fields, drives every mux select and write enable of the datapath, and stalls on a memory-ready handshake. Supported subset: lw, sw, R-type add/sub/and/or/slt, I-type addi/andi/ori/slti, beq, jal.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset; 0 = asserted
- op  in  7  Instr[6:0]
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0 PC, 1 Result
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction and OldPC register enable
- RegWrite  out  1  register-file write enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 register
- ALUSrcB  out  2  00 rs2 register, 01 ImmExt, 10 constant 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- Illegal  out  1  one-cycle pulse on unsupported encoding

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- FETCH: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, add, ResultSrc 10; IRWrite = PCWrite = MemReady; stay until MemReady, then DECODE.
- DECODE: ALUSrcA 01, ALUSrcB 01, add (branch target into ALUOut). Next: lw/sw to MEMADR, R to EXECR, I to EXECI, beq to BEQ, jal to JAL; anything else: Illegal = 1, next FETCH.
- MEMADR: ALUSrcA 10, ALUSrcB 01, add; lw to MEMREAD, sw to MEMWRITE.
- MEMREAD: ResultSrc 00, AdrSrc 1; hold until MemReady, then MEMWB.
- MEMWB: ResultSrc 01, RegWrite 1; to FETCH.
- MEMWRITE: ResultSrc 00, AdrSrc 1, MemWrite 1 held until MemReady; then FETCH.
- EXECR: ALUSrcA 10, ALUSrcB 00, ALUOp funct; EXECI: ALUSrcA 10, ALUSrcB 01, ALUOp funct; both to ALUWB.
- ALUWB: ResultSrc 00, RegWrite 1; to FETCH.
- JAL: ALUSrcA 01, ALUSrcB 10, add, ResultSrc 00, PCWrite 1; to ALUWB.
- BEQ: ALUSrcA 10, ALUSrcB 00, sub, ResultSrc 00, PCWrite = Zero; to FETCH.
- ALU decode (ALUOp add/sub/funct): funct3 000 -> sub only if R-type and funct7b5, else add; 010 slt; 110 or; 111 and. Unsupported funct3 for R/I, or beq with funct3 != 000, is illegal in DECODE.
- ImmSrc is combinational from op in every state: lw/I -> 00, sw -> 01, beq -> 10, jal -> 11, other -> 00.
- Unlisted outputs in a state: enables 0, selects 00, ALUControl add.

## Timing
- State register only; all outputs combinational from state, op/funct fields, Zero, MemReady.
- While reset low: state forced to FETCH asynchronously; PCWrite, IRWrite, RegWrite, MemWrite, Illegal forced 0; selects show FETCH values. First fetch completes on the first edge after release with MemReady = 1.
- Reset mid-instruction abandons it; no partial write enable reaches an edge.
- With MemReady held 1, cycles per instruction: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2. Each MemReady-low cycle in FETCH/MEMREAD/MEMWRITE adds one.
- MemWrite stays high across stall cycles; the write commits on the MemReady edge.

## Structure
- Package ctrl_pkg: state enum, opcode constants, ALUControl/ResultSrc/ALUSrc/ImmSrc encodings, ALUOp enum.
- Sub-module aludec: combinational (ALUOp, funct3, funct7b5, op[5]) -> ALUControl plus illegal-funct flag.

## Test plan
- Reset low mid-MEMWRITE, MemReady 0 -> all enables 0 immediately; after release FETCH, IRWrite = PCWrite = 1 when MemReady = 1.
- lw (op 0000011), MemReady always 1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite 1 with ResultSrc 01 in cycle 5.
- sw with MemReady 0 for 3 cycles in MEMWRITE -> MemWrite high 4 cycles, then FETCH.
- R-type sub (funct3 000, funct7b5 1) -> ALUControl 001 in EXECR; addi with Instr[30] = 1 -> 000.
- beq with Zero 1 then Zero 0 -> PCWrite 1 / 0 in BEQ, 3 cycles each.
- op 1111111, or R-type funct3 001 -> Illegal pulse in DECODE, no write enable, back to FETCH.
